// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI master arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RECOVER = 2'd3
   } arb_state_e;

   localparam int DEF_SETUP_CYCLES   = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   // Index of the set bit in a one-hot vector of up to eight requesters.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) begin
            idx = idx | 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  winner_o,
   output logic          valid_o
);

   logic         found_s;
   logic [PW:0]  pos_s;

   // Scan requesters starting at the pointer, wrapping, and keep the first hit.
   always_comb begin
      winner_o = '0;
      found_s  = 1'b0;
      pos_s    = '0;
      for (int k = 0; k < N; k++) begin
         pos_s = {1'b0, ptr_i} + (PW+1)'(k);
         if (pos_s >= (PW+1)'(N)) begin
            pos_s = pos_s - (PW+1)'(N);
         end else begin
            pos_s = pos_s;
         end
         if (!found_s && req_i[pos_s[PW-1:0]]) begin
            winner_o[pos_s[PW-1:0]] = 1'b1;
            found_s                 = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      valid_o = |req_i;
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master between N requesters with round-robin arbitration,
// latching the winner's byte and mode and sequencing start/finish.
module spi_master_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N              = 4,
   parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] txdata,
   input  logic [N-1:0]   cpol,
   input  logic [N-1:0]   cpha,
   output logic [N-1:0]   grant,
   output logic [N-1:0]   done,
   output logic [N-1:0]   err,
   output logic [7:0]     rxdata,
   output logic [N-1:0]   cs_sel,
   output logic           m_start,
   output logic [7:0]     m_datain,
   output logic           m_cpol,
   output logic           m_cpha,
   input  logic           m_finish,
   input  logic [7:0]     m_dataout
);

   localparam int PW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e    state_q;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] idx_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  grant_q;
   logic [N-1:0]  done_q;
   logic [N-1:0]  err_q;
   logic [7:0]    rxdata_q;
   logic          m_start_q;
   logic [7:0]    m_datain_q;
   logic          m_cpol_q;
   logic          m_cpha_q;

   logic [N-1:0]  win_oh_s;
   logic          win_valid_s;
   logic [PW-1:0] win_idx_s;
   logic [PW-1:0] ptr_d;

   rr_arbiter #(.N(N), .PW(PW)) u_rr (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .winner_o (win_oh_s),
      .valid_o  (win_valid_s)
   );

   assign win_idx_s = PW'(onehot_to_idx(8'(win_oh_s)));

   // Pointer moves to the requester after the one just served, wrapping at N.
   always_comb begin
      if (idx_q == PW'(N - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = idx_q + 1'b1;
      end
   end

   // Transfer sequencer: arbitrate, hold mode stable, launch, await finish or timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         err_q      <= '0;
         rxdata_q   <= 8'h00;
         m_start_q  <= 1'b0;
         m_datain_q <= 8'h00;
         m_cpol_q   <= 1'b0;
         m_cpha_q   <= 1'b0;
      end else begin
         done_q <= '0;
         err_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (win_valid_s) begin
                  grant_q    <= win_oh_s;
                  idx_q      <= win_idx_s;
                  m_datain_q <= txdata[{win_idx_s, 3'b000} +: 8];
                  m_cpol_q   <= cpol[win_idx_s];
                  m_cpha_q   <= cpha[win_idx_s];
                  cnt_q      <= '0;
                  state_q    <= ST_SETUP;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                  m_start_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= ST_BUSY;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_BUSY: begin
               if (m_finish) begin
                  m_start_q <= 1'b0;
                  rxdata_q  <= m_dataout;
                  done_q    <= grant_q;
                  grant_q   <= '0;
                  ptr_q     <= ptr_d;
                  state_q   <= ST_RECOVER;
               end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  m_start_q <= 1'b0;
                  err_q     <= grant_q;
                  grant_q   <= '0;
                  ptr_q     <= ptr_d;
                  state_q   <= ST_RECOVER;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RECOVER: begin
               // A level-style finish must fall before the next arbitration.
               if (m_finish) begin
                  state_q <= ST_RECOVER;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               m_start_q <= 1'b0;
               grant_q   <= '0;
            end
         endcase
      end
   end

   assign grant    = grant_q;
   assign cs_sel   = grant_q;
   assign done     = done_q;
   assign err      = err_q;
   assign rxdata   = rxdata_q;
   assign m_start  = m_start_q;
   assign m_datain = m_datain_q;
   assign m_cpol   = m_cpol_q;
   assign m_cpha   = m_cpha_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a behavioural spi_master model.
module tb_spi_master_arbiter;

   localparam int N  = 4;
   localparam int SC = 2;
   localparam int TO = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, cpol, cpha;
   logic [8*N-1:0] txdata;
   logic [N-1:0]   grant, done, err, cs_sel;
   logic [7:0]     rxdata, m_datain, m_dataout;
   logic           m_start, m_cpol, m_cpha, m_finish;

   always #5 clk = ~clk;

   spi_master_arbiter #(.N(N), .SETUP_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .txdata(txdata), .cpol(cpol), .cpha(cpha),
      .grant(grant), .done(done), .err(err), .rxdata(rxdata), .cs_sel(cs_sel),
      .m_start(m_start), .m_datain(m_datain), .m_cpol(m_cpol), .m_cpha(m_cpha),
      .m_finish(m_finish), .m_dataout(m_dataout)
   );

   typedef struct {
      int         idx;
      bit         is_err;
      logic [7:0] rx;
      int         cyc;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] tx_exp[N];
   logic       pol_exp[N];
   logic       pha_exp[N];
   int         force_mode = 0;
   logic [7:0] force_rx = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Round-robin rule: first pending requester at or after ptr, wrapping.
   function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic raise(input int i, input logic [7:0] d, input logic p, input logic h);
      req[i]          = 1'b1;
      txdata[8*i +: 8] = d;
      cpol[i]         = p;
      cpha[i]         = h;
      tx_exp[i]       = d;
      pol_exp[i]      = p;
      pha_exp[i]      = h;
   endtask

   // One clock of requester behaviour: drop on completion, scramble after grant, maybe request.
   task automatic step(input int pct);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (done[i] || err[i]) begin
            req[i] = 1'b0;
         end else if (grant[i]) begin
            txdata[8*i +: 8] = 8'($urandom);
            cpol[i] = 1'($urandom);
            cpha[i] = 1'($urandom);
         end else if (!req[i] && ($urandom_range(0, 99) < pct)) begin
            raise(i, 8'($urandom), 1'($urandom), 1'($urandom));
         end
      end
   endtask

   task automatic run(input int n, input int pct);
      repeat (n) step(pct);
   endtask

   // Cycle counter: after rising edge k, cyc == k.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // spi_master model: reacts to m_start, decides the outcome and books the expected result.
   initial begin
      int s, idx, d, hold, kind;
      logic [7:0] data;
      m_finish  = 1'b0;
      m_dataout = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (m_start && !rst) begin
            s = cyc;
            idx = 0;
            for (int i = 0; i < N; i++) if (grant[i]) idx = i;
            data = 8'($urandom);
            d = $urandom_range(0, 4);
            hold = 1;
            kind = 1;
            case (force_mode)
               1: begin d = 3; data = force_rx; end
               2: kind = 0;
               3: begin d = 1; hold = 5; end
               4: kind = 1;
               default: begin
                  kind = ($urandom_range(0, 7) == 0) ? 0 : 1;
                  if ($urandom_range(0, 3) == 0) hold = $urandom_range(2, 5);
               end
            endcase
            if (kind == 0) begin
               sb_q.push_back('{idx, 1'b1, 8'h00, s + TO});
               while (m_start) begin
                  @(posedge clk);
                  #1;
               end
            end else begin
               repeat (d) begin
                  @(posedge clk);
                  #1;
               end
               m_finish  = 1'b1;
               m_dataout = data;
               sb_q.push_back('{idx, 1'b0, data, cyc + 1});
               repeat (hold) begin
                  @(posedge clk);
                  #1;
               end
               m_finish  = 1'b0;
               m_dataout = 8'($urandom);
            end
         end
      end
   end

   // Monitor: checks completions against the scoreboard and grants against the RR rule.
   int          model_ptr = 0;
   logic [7:0]  rx_model = 8'h00;
   int          last_end = -100;
   int          grant_cyc = 0;
   int          g_idx = 0;
   int          fin_low_run = 0;
   bit          in_setup = 1'b0;
   logic [N-1:0] prev_grant = '0;
   logic [N-1:0] req_prev = '0;
   int          wait_cnt[N];
   initial begin
      exp_t e;
      int w;
      logic [31:0] exp_g;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb_q.delete();
            model_ptr  = 0;
            rx_model   = 8'h00;
            last_end   = -100;
            in_setup   = 1'b0;
            prev_grant = '0;
            req_prev   = '0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
         end else begin
            if ((done | err) != '0) begin
               chk("done_err_excl", 32'((|done) && (|err)), 32'd0);
               if (sb_q.size() == 0) begin
                  chk("unexpected_completion", 32'(done | err), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  if (e.is_err) begin
                     chk("err_vec", 32'(err), 32'd1 << e.idx);
                     chk("rx_held", 32'(rxdata), 32'(rx_model));
                  end else begin
                     chk("done_vec", 32'(done), 32'd1 << e.idx);
                     chk("rxdata", 32'(rxdata), 32'(e.rx));
                     rx_model = e.rx;
                  end
                  chk("end_cycle", 32'(cyc), 32'(e.cyc));
                  chk("grant_clear", 32'(grant), 32'd0);
                  chk("mstart_clear", 32'(m_start), 32'd0);
                  model_ptr = (e.idx + 1) % N;
                  last_end  = cyc;
               end
            end
            if (grant != '0 && prev_grant == '0) begin
               w = rr_pick(model_ptr, req_prev);
               exp_g = (w < 0) ? 32'd0 : (32'd1 << w);
               chk("grant", 32'(grant), exp_g);
               chk("cs_sel", 32'(cs_sel), exp_g);
               chk("idle_gap", 32'((cyc - last_end) >= 2), 32'd1);
               chk("finish_low", 32'(fin_low_run >= 2), 32'd1);
               chk("grant_mstart_low", 32'(m_start), 32'd0);
               if (w >= 0) begin
                  g_idx = w;
                  chk("latch_data", 32'(m_datain), 32'(tx_exp[w]));
                  chk("latch_mode", 32'({m_cpol, m_cpha}), 32'({pol_exp[w], pha_exp[w]}));
                  for (int i = 0; i < N; i++) begin
                     if (i == w || !req_prev[i]) begin
                        wait_cnt[i] = 0;
                     end else begin
                        wait_cnt[i]++;
                        chk("starvation", 32'(wait_cnt[i] <= N - 1), 32'd1);
                     end
                  end
               end
               grant_cyc = cyc;
               in_setup  = (w >= 0);
            end else if (in_setup) begin
               chk("mode_stable", 32'({m_datain, m_cpol, m_cpha}),
                   32'({tx_exp[g_idx], pol_exp[g_idx], pha_exp[g_idx]}));
               if (cyc < grant_cyc + SC) begin
                  chk("setup_mstart_low", 32'(m_start), 32'd0);
               end else begin
                  chk("mstart_latency", 32'(m_start), 32'd1);
                  in_setup = 1'b0;
               end
            end
            prev_grant = grant;
            req_prev   = req;
         end
         fin_low_run = m_finish ? 0 : fin_low_run + 1;
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed phases followed by randomized traffic.
   initial begin
      int k;
      rst = 1'b1; req = '0; txdata = '0; cpol = '0; cpha = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_cs_sel", 32'(cs_sel), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rxdata", 32'(rxdata), 32'd0);
      chk("rst_mstart", 32'(m_start), 32'd0);
      chk("rst_mdatain", 32'(m_datain), 32'd0);
      chk("rst_mode", 32'({m_cpol, m_cpha}), 32'd0);
      rst = 1'b0;
      run(2, 0);

      force_mode = 1; force_rx = 8'h3C;
      raise(0, 8'hA5, 1'b0, 1'b0);
      run(20, 0);
      chk("single_rx", 32'(rxdata), 32'h3C);

      force_mode = 4;
      raise(0, 8'h11, 1'b0, 1'b0);
      raise(1, 8'h22, 1'b1, 1'b1);
      raise(2, 8'h33, 1'b0, 1'b0);
      raise(3, 8'h44, 1'b1, 1'b0);
      run(70, 100);

      force_mode = 2;
      run(90, 100);
      force_mode = 3;
      run(40, 100);
      force_mode = 0;
      run(3000, 25);

      k = 0;
      while (k < 600 && !(req == '0 && grant == '0)) begin
         step(0);
         k++;
      end
      chk("drain", 32'(req == '0 && grant == '0), 32'd1);
      run(5, 0);

      force_mode = 4;
      raise(1, 8'h77, 1'b0, 1'b1);
      run(20, 0);

      force_mode = 2;
      raise(2, 8'h5A, 1'b1, 1'b0);
      k = 0;
      while (k < 20 && !m_start) begin
         step(0);
         k++;
      end
      chk("reach_busy", 32'(m_start), 32'd1);
      run(3, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = '0;
      @(posedge clk);
      #1;
      chk("midrst_mstart", 32'(m_start), 32'd0);
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_cs_sel", 32'(cs_sel), 32'd0);
      chk("midrst_done_err", 32'({done, err}), 32'd0);
      rst = 1'b0;
      run(3, 0);

      force_mode = 1; force_rx = 8'hC3;
      raise(1, 8'h96, 1'b0, 1'b1);
      raise(3, 8'h69, 1'b1, 1'b1);
      run(60, 0);
      raise(2, 8'h0F, 1'b0, 1'b0);
      run(20, 0);
      chk("rx_after_reset", 32'(rxdata), 32'hC3);
      run(10, 0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
